// File: rtl/hc595_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hc595_seg_scan
// Purpose  : Multiplexed 7-segment scanner driving two chained 74HC595s.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module hc595_seg_scan #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 4,
    parameter int SCAN_HOLD      = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lockdata,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic                  clk595,
    output logic                  out595,
    output logic                  lock595,
    output logic                  frame_done
);

    localparam int c_maxc = (CLK_DIV > SCAN_HOLD) ? CLK_DIV : SCAN_HOLD;
    localparam int c_cw   = (c_maxc > 1) ? $clog2(c_maxc) : 1;
    localparam int c_dw   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cw-1:0] c_div_last  = c_cw'(CLK_DIV - 1);
    localparam logic [c_cw-1:0] c_hold_last = c_cw'(SCAN_HOLD - 1);
    localparam logic [c_dw-1:0] c_dig_last  = c_dw'(DIGITS - 1);

    localparam logic [1:0] c_shift_lo = 2'd0;
    localparam logic [1:0] c_shift_hi = 2'd1;
    localparam logic [1:0] c_latch    = 2'd2;
    localparam logic [1:0] c_hold     = 2'd3;

    logic [1:0]          r_state;
    logic [c_cw-1:0]     r_cnt;
    logic [3:0]          r_bit;
    logic [c_dw-1:0]     r_digit;
    logic [15:0]         r_word;
    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;

    logic [3:0]  w_nib;
    logic        w_dpbit;
    logic [6:0]  w_seg7;
    logic        w_blank;
    logic [7:0]  w_seg;
    logic [7:0]  w_sel;
    logic [15:0] w_built;
    logic        w_first;
    logic [15:0] w_word;

    always_comb begin
        w_nib   = 4'h0;
        w_dpbit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == c_dw'(i)) begin
                w_nib   = r_data[4*i +: 4];
                w_dpbit = r_dp[i];
            end
        end
    end

    always_comb begin
        case (w_nib)
            4'h0:    w_seg7 = 7'h3F;
            4'h1:    w_seg7 = 7'h06;
            4'h2:    w_seg7 = 7'h5B;
            4'h3:    w_seg7 = 7'h4F;
            4'h4:    w_seg7 = 7'h66;
            4'h5:    w_seg7 = 7'h6D;
            4'h6:    w_seg7 = 7'h7D;
            4'h7:    w_seg7 = 7'h07;
            4'h8:    w_seg7 = 7'h7F;
            4'h9:    w_seg7 = 7'h6F;
            4'hA:    w_seg7 = 7'h77;
            4'hB:    w_seg7 = 7'h7C;
            4'hC:    w_seg7 = 7'h39;
            4'hD:    w_seg7 = 7'h5E;
            4'hE:    w_seg7 = 7'h79;
            default: w_seg7 = 7'h71;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more significant nibble are zero.
    always_comb begin
        w_blank = (r_digit != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((c_dw'(i) >= r_digit) && (r_data[4*i +: 4] != 4'h0)) begin
                w_blank = 1'b0;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg   = {w_dpbit, w_blank ? 7'h00 : w_seg7};
    assign w_sel   = 8'h01 << r_digit;
    assign w_built = {(SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg,
                      (SEL_ACTIVE_LOW != 0) ? ~w_sel : w_sel};

    // The first frame cycle shows the freshly built word so that bit 15 is
    // valid immediately; it is frozen into r_word at the end of that cycle.
    assign w_first = (r_state == c_shift_lo) && (r_bit == 4'd15) && (r_cnt == '0);
    assign w_word  = w_first ? w_built : r_word;

    assign clk595     = (r_state == c_shift_hi);
    assign lock595    = (r_state == c_latch);
    assign frame_done = (r_state == c_latch) && (r_cnt == c_div_last) &&
                        (r_digit == c_dig_last);
    assign out595     = ~rst && ((r_state == c_shift_lo) || (r_state == c_shift_hi)) &&
                        w_word[r_bit];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_shift_lo;
            r_cnt   <= '0;
            r_bit   <= 4'd15;
            r_digit <= '0;
            r_word  <= '0;
            r_data  <= '0;
            r_dp    <= '0;
        end else begin
            if (lockdata) begin
                r_data <= data;
                r_dp   <= dp;
            end
            case (r_state)
                c_shift_lo: begin
                    if (w_first) r_word <= w_built;
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_state <= c_shift_hi;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_shift_hi: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt <= '0;
                        if (r_bit == 4'd0) begin
                            r_state <= c_latch;
                        end else begin
                            r_bit   <= r_bit - 4'd1;
                            r_state <= c_shift_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_latch: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        r_state <= c_hold;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == c_hold_last) begin
                        r_cnt   <= '0;
                        r_bit   <= 4'd15;
                        r_state <= c_shift_lo;
                        r_digit <= (r_digit == c_dig_last) ? '0 : r_digit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hc595_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hc595_seg_scan
// Purpose  : Randomized self-checking bench with a frame-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_seg_scan;

    localparam int D  = 2;
    localparam int H  = 4;
    localparam int ND = 8;
    localparam int L  = 32*D + D + H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lockdata = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp = '0;
    logic        clk595, out595, lock595, frame_done;

    logic        rst1 = 1'b1;
    logic        lockdata1 = 1'b0;
    logic [3:0]  data1 = 4'hF;
    logic [0:0]  dp1 = 1'b1;
    logic        clk1, out1, lock1, fd1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hc595_seg_scan #(.DIGITS(ND), .CLK_DIV(D), .SCAN_HOLD(H),
                     .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .lockdata(lockdata), .data(data), .dp(dp),
        .clk595(clk595), .out595(out595), .lock595(lock595), .frame_done(frame_done));

    hc595_seg_scan #(.DIGITS(1), .CLK_DIV(1), .SCAN_HOLD(1),
                     .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst(rst1), .lockdata(lockdata1), .data(data1), .dp(dp1),
        .clk595(clk1), .out595(out1), .lock595(lock1), .frame_done(fd1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [15:0] frame_word(input logic [31:0] dv, input logic [7:0] dpv,
                                               input int d);
        logic [3:0] nib;
        logic [7:0] seg;
        nib = 4'((dv >> (4*d)) & 32'hF);
        seg = {dpv[d], segtab[nib]};
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (dv >> (4*d)) == 32'd0) seg[6:0] = 7'h00;
`endif
        return {~seg, 8'(1 << d)};
    endfunction

    // Model: cycles since reset release and the captured shadow value.
    int          t;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= 0; m_data <= '0; m_dp <= '0;
        end else begin
            t <= t + 1;
            if (lockdata) begin
                m_data <= data; m_dp <= dp;
            end
        end
    end

    logic [15:0] m_word, shreg;
    logic [15:0] word_log [128];
    logic [3:0]  exp_v, mask;
    logic        pclk = 1'b0, plock = 1'b0;
    int          abs_c = 0, last_lock = 0, last_fd = 0, lockw = 0;
    bit          have_lock = 0, have_fd = 0;

    initial begin
        int pos, f, d;
        m_word = '0; shreg = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", 32'({clk595, out595, lock595, frame_done}), 32'd0);
                have_lock = 0; have_fd = 0; lockw = 0;
            end else begin
                pos = t % L; f = t / L; d = f % ND;
                if (pos == 0) m_word = frame_word(m_data, m_dp, d);
                if (pos < 32*D) begin
                    exp_v = {1'((pos / D) % 2), m_word[15 - pos/(2*D)], 1'b0, 1'b0};
                    mask  = 4'hF;
                end else begin
                    exp_v = {1'b0, 1'b0, 1'(pos < 33*D), 1'(pos == 33*D-1 && d == ND-1)};
                    mask  = 4'b1011;
                end
                chk("outputs", 32'({clk595, out595, lock595, frame_done} & mask),
                    32'(exp_v & mask));
                if (clk595 && !pclk) shreg = {shreg[14:0], out595};
                if (lock595 && !plock) begin
                    word_log[f % 128] = shreg;
                    chk("latched_word", 32'(shreg), 32'(m_word));
                    if (have_lock) chk("frame_len", abs_c - last_lock, L);
                    have_lock = 1; last_lock = abs_c;
                end
                if (lock595) lockw++;
                else if (plock) begin
                    chk("lock_width", lockw, D);
                    lockw = 0;
                end
                if (frame_done) begin
                    if (have_fd) chk("frame_done_period", abs_c - last_fd, L*ND);
                    have_fd = 1; last_fd = abs_c;
                end
            end
            pclk = clk595; plock = lock595; abs_c++;
        end
    end

    // Single-digit instance: fixed word, 34-cycle frames, frame_done each frame.
    logic [15:0] sh1 = '0;
    logic        pclk1 = 1'b0, plock1 = 1'b0;
    int          nfr1 = 0, abs1 = 0, last1 = 0, lastfd1 = 0;
    bit          have1 = 0, havefd1 = 0;
    initial begin
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0; lockdata1 = 1'b1;
        @(posedge clk);
        #1 lockdata1 = 1'b0;
    end
    initial begin
        forever begin
            @(negedge clk);
            if (!rst1) begin
                if (clk1 && !pclk1) sh1 = {sh1[14:0], out1};
                if (lock1 && !plock1) begin
                    nfr1++;
                    if (nfr1 >= 2) chk("dig1_word", 32'(sh1), 32'h0E01);
                    if (have1) chk("dig1_len", abs1 - last1, 34);
                    have1 = 1; last1 = abs1;
                end
                if (fd1) begin
                    if (havefd1) chk("dig1_done_period", abs1 - lastfd1, 34);
                    havefd1 = 1; lastfd1 = abs1;
                end
            end
            pclk1 = clk1; plock1 = lock1; abs1++;
        end
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (t < target && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        if (t < target) chk("wait_timeout", 32'(t), 32'(target));
    endtask

    task automatic pulse(input logic [31:0] dv, input logic [7:0] dpv, input int len);
        data = dv; dp = dpv; lockdata = 1'b1;
        repeat (len) @(posedge clk);
        #1 lockdata = 1'b0;
    endtask

    logic [7:0] s28 [8] = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_clk595", 32'(clk595), 32'd0);
        chk("reset_out595", 32'(out595), 32'd0);
        chk("reset_lock595", 32'(lock595), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse(32'h12345678, 8'h00, 1);
        wait_t(16*L + 2);
        chk("first_frame_zero_data", 32'(word_log[0]), 32'hC001);
        chk("digit0_word_literal", 32'(word_log[8]), 32'h8001);
        for (int k = 0; k < 8; k++)
            chk("digit_word", 32'(word_log[8+k]), 32'({~s28[k], 8'(1 << k)}));

        wait_t(16*L + 16);
        pulse(32'h0000000A, 8'h00, 1);
        wait_t(25*L + 2);
        chk("no_tearing", 32'(word_log[16]), 32'h8001);
        chk("digit0_A", 32'(word_log[24]), 32'h8801);
        for (int k = 1; k < 8; k++)
`ifdef LEADING_ZERO_BLANK_EN
            chk("upper_digit", 32'(word_log[16+k]), 32'({8'hFF, 8'(1 << k)}));
`else
            chk("upper_digit", 32'(word_log[16+k]), 32'({8'hC0, 8'(1 << k)}));
`endif

        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(5, 150)) @(posedge clk);
            #1;
            pulse($urandom >> (4 * $urandom_range(0, 7)), 8'($urandom), $urandom_range(1, 3));
        end

        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(posedge clk); #1;
            if ((t / L) % ND == 3 && t % L == 33) found = 1;
        end
        chk("found_digit3_bit7", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({clk595, out595, lock595, frame_done}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_t(L + 2);
        chk("post_reset_frame", 32'(word_log[0]), 32'hC001);
        chk("dig1_frames_seen", 32'(nfr1 >= 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
